// File: rtl/sync_fifo_flags_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags_pkg
// Shared types and width helpers for the sync_fifo_flags block.
//   ptr_w(depth)  : pointer width for a FIFO of 'depth' entries
//   cnt_w(depth)  : occupancy counter width (must represent 0..depth)
//   is_pow2(n)    : true when n is a power of two
//   fifo_err_e    : index of each sticky error bit in the error vector
// -----------------------------------------------------------------------------
package sync_fifo_flags_pkg;

    typedef enum logic {
        ERR_OVF = 1'b0,
        ERR_UNF = 1'b1
    } fifo_err_e;

    localparam int ERR_NUM = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that a completely full FIFO (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags_if
// Bundles the producer/consumer side of sync_fifo_flags.
//   master modport : the stage that writes, reads and clears errors
//   slave modport  : the FIFO itself
// Signals: wdata, wr_en, rd_en, err_clr (master -> slave);
//          rdata, full_flag, almost_full, empty_flag, almost_empty,
//          count, ovf_err, unf_err (slave -> master).
// -----------------------------------------------------------------------------
interface sync_fifo_flags_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CNT_W = sync_fifo_flags_pkg::cnt_w(DEPTH);

    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             full_flag;
    logic             almost_full;
    logic [WIDTH-1:0] rdata;
    logic             rd_en;
    logic             empty_flag;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             ovf_err;
    logic             unf_err;
    logic             err_clr;

    modport master (
        output wdata, wr_en, rd_en, err_clr,
        input  rdata, full_flag, almost_full, empty_flag, almost_empty,
               count, ovf_err, unf_err
    );

    modport slave (
        input  wdata, wr_en, rd_en, err_clr,
        output rdata, full_flag, almost_full, empty_flag, almost_empty,
               count, ovf_err, unf_err
    );

endinterface

// File: rtl/sync_fifo_flags_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags_mem
// DEPTH x WIDTH register array storage for sync_fifo_flags.
// One synchronous write port, one asynchronous read port. Contents are not
// reset; the controller never reads a location it has not written.
// Ports:
//   clk    : clock
//   we     : write enable (already qualified by the controller)
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : combinational read data, ram[raddr]
// -----------------------------------------------------------------------------
module sync_fifo_flags_mem
    import sync_fifo_flags_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ptr_w(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [ptr_w(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end

    // DEPTH is a power of two, so every address value is a valid index.
    assign rdata = ram[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds
// and sticky overflow/underflow error flags.
//
// Build option: macro SYNC_FIFO_FWFT_EN
//   undefined : standard read, rdata registered, valid one cycle after the
//               accepted read edge and held otherwise.
//   defined   : first-word-fall-through, rdata shows the head word whenever
//               the FIFO is not empty (zero when empty); rd_en pops it.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, overrides every other input
//   fifo  : sync_fifo_flags_if.slave (data, handshakes, flags, count, errors)
//
// Parameters: WIDTH, DEPTH (power of two, >= 2), AF_MARGIN, AE_MARGIN.
//   almost_full  = count >= DEPTH - AF_MARGIN
//   almost_empty = count <= AE_MARGIN
// -----------------------------------------------------------------------------
module sync_fifo_flags
    import sync_fifo_flags_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 1
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_flags_if.slave   fifo
);

    localparam int ADDR_W = ptr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t AF_LEVEL = cnt_t'(DEPTH - AF_MARGIN);
    localparam cnt_t AE_LEVEL = cnt_t'(AE_MARGIN);

    generate
        if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo_flags: DEPTH must be a power of two and >= 2");
        end
        if (AF_MARGIN < 0 || AF_MARGIN >= DEPTH) begin : g_bad_af
            $error("sync_fifo_flags: AF_MARGIN out of range");
        end
        if (AE_MARGIN < 0 || AE_MARGIN >= DEPTH) begin : g_bad_ae
            $error("sync_fifo_flags: AE_MARGIN out of range");
        end
    endgenerate

    ptr_t                 wr_ptr;
    ptr_t                 rd_ptr;
    cnt_t                 count_q;
    cnt_t                 count_nxt;
    logic                 full_q;
    logic                 empty_q;
    logic                 af_q;
    logic                 ae_q;
    logic [ERR_NUM-1:0]   err_q;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 wr_rej;
    logic                 rd_rej;
    logic [WIDTH-1:0]     mem_rdata;

    // Acceptance is decided purely on registered flags, so a full FIFO never
    // takes a write even if a read frees a slot in the same cycle, and an
    // empty FIFO never forwards a same-cycle write to the read side.
    always_comb begin
        wr_acc    = !rst && fifo.wr_en && !full_q;
        rd_acc    = !rst && fifo.rd_en && !empty_q;
        wr_rej    = fifo.wr_en && full_q;
        rd_rej    = fifo.rd_en && empty_q;
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + cnt_t'(1);
            2'b01:   count_nxt = count_q - cnt_t'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Flags are registered from the next count so they line up with count
    // itself, visible the cycle after the edge that accepted the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= (AF_LEVEL == '0);
            ae_q    <= 1'b1;
            err_q   <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_FULL);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= AF_LEVEL);
            ae_q    <= (count_nxt <= AE_LEVEL);
            // A fresh error beats a simultaneous clear.
            err_q[ERR_OVF] <= wr_rej || (err_q[ERR_OVF] && !fifo.err_clr);
            err_q[ERR_UNF] <= rd_rej || (err_q[ERR_UNF] && !fifo.err_clr);
        end
    end

    sync_fifo_flags_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (fifo.wdata),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; the memory location under rd_ptr is
    // stale while empty, so it is masked to zero.
    assign fifo.rdata = empty_q ? '0 : mem_rdata;
`else
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= mem_rdata;
        end
    end

    assign fifo.rdata = rdata_q;
`endif

    assign fifo.count        = count_q;
    assign fifo.full_flag    = full_q;
    assign fifo.empty_flag   = empty_q;
    assign fifo.almost_full  = af_q;
    assign fifo.almost_empty = ae_q;
    assign fifo.ovf_err      = err_q[ERR_OVF];
    assign fifo.unf_err      = err_q[ERR_UNF];

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
// Directed bench for sync_fifo_flags (WIDTH=32, DEPTH=8, AF_MARGIN=2,
// AE_MARGIN=1). Builds in either read mode depending on SYNC_FIFO_FWFT_EN.
// Stimulus keeps a reference queue; every accepted read pushes the expected
// word into a scoreboard that an independent monitor drains when the DUT
// presents read data.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

    logic clk;
    logic rst;

    sync_fifo_flags_if #(.WIDTH(32), .DEPTH(8)) bus ();

    sync_fifo_flags #(
        .WIDTH     (32),
        .DEPTH     (8),
        .AF_MARGIN (2),
        .AE_MARGIN (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_q[$];
    logic [31:0] sb_q[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [31:0] m_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [31:0] exp_rd;
        int          n;
        n = m_q.size();
`ifdef SYNC_FIFO_FWFT_EN
        exp_rd = (n == 0) ? 32'h0 : m_q[0];
`else
        exp_rd = m_rdata;
`endif
        chk("count",        32'(bus.count),   32'(n));
        chk("full_flag",    32'(bus.full_flag),    32'(n == 8));
        chk("empty_flag",   32'(bus.empty_flag),   32'(n == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(n >= 6));
        chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 1));
        chk("ovf_err",      32'(bus.ovf_err), 32'(m_ovf));
        chk("unf_err",      32'(bus.unf_err), 32'(m_unf));
        chk("rdata",        bus.rdata, exp_rd);
    endtask

    // One clock of stimulus; the reference model advances with it.
    task automatic step(input logic w, input logic [31:0] d, input logic r, input logic c);
        logic aw;
        logic ar;
        int   n;
        n = m_q.size();
        bus.wr_en   = w;
        bus.wdata   = d;
        bus.rd_en   = r;
        bus.err_clr = c;
        aw    = w && (n < 8);
        ar    = r && (n > 0);
        m_ovf = (w && (n == 8)) || (m_ovf && !c);
        m_unf = (r && (n == 0)) || (m_unf && !c);
        if (ar) begin
            m_rdata = m_q.pop_front();
            sb_q.push_back(m_rdata);
        end
        if (aw) m_q.push_back(d);
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        check_state();
    endtask

    // Reset with every other input asserted to show reset overrides them.
    task automatic do_reset();
        rst         = 1'b1;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.err_clr = 1'b1;
        bus.wdata   = 32'hDEAD_BEEF;
        m_q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = '0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        check_state();
    endtask

    task automatic pop_check();
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected actual=%h expected=none t=%0t", bus.rdata, $time);
        end else begin
            exp = sb_q.pop_front();
            chk("rd_data", bus.rdata, exp);
        end
    endtask

    // Monitor: independent of stimulus, decides from DUT flags when a read
    // was presented and compares against the scoreboard.
`ifdef SYNC_FIFO_FWFT_EN
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.rd_en && !bus.empty_flag) pop_check();
        end
    end
`else
    initial begin
        logic fire;
        forever begin
            @(posedge clk);
            fire = !rst && bus.rd_en && !bus.empty_flag;
            @(negedge clk);
            if (fire) pop_check();
        end
    end
`endif

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        bus.wdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();

        // Fill with alternating pattern.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i % 2 == 0) ? 32'hD4F4_0099 : 32'h281B_86C4, 1'b0, 1'b0);
            if (i == 4) chk("af_at_5", 32'(bus.almost_full), 32'd0);
            if (i == 5) chk("af_at_6", 32'(bus.almost_full), 32'd1);
            if (i == 1) chk("ae_at_2", 32'(bus.almost_empty), 32'd0);
        end
        chk("full_after_8", 32'(bus.full_flag), 32'd1);
        chk("count_after_8", 32'(bus.count), 32'd8);

        // Overflow attempt.
        step(1'b1, 32'hBABA_BABA, 1'b0, 1'b0);
        chk("ovf_set", 32'(bus.ovf_err), 32'd1);
        chk("count_ovf", 32'(bus.count), 32'd8);

        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Underflow attempt, then clear both errors.
        step(1'b0, '0, 1'b1, 1'b0);
        chk("unf_set", 32'(bus.unf_err), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus.ovf_err), 32'd0);
        chk("unf_clr", 32'(bus.unf_err), 32'd0);

        // Simultaneous read/write at count 4, then at full.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
        chk("count_rw_4", 32'(bus.count), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'hD000_0000, 1'b1, 1'b0);
        chk("count_full_rw", 32'(bus.count), 32'd7);
        chk("ovf_full_rw", 32'(bus.ovf_err), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        while (m_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);

        // Empty + write + read: only the write lands.
        step(1'b1, 32'h5555_AAAA, 1'b1, 1'b0);
        chk("unf_empty_rw", 32'(bus.unf_err), 32'd1);
        step(1'b0, '0, 1'b1, 1'b1);

        // Interleaved traffic wrapping both pointers.
        for (int i = 1; i <= 20; i++) step(1'b1, 32'(i), (i % 4) != 1, 1'b0);
        while (m_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-stream.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h7700_0000 + 32'(i), 1'b0, 1'b0);
        do_reset();
        chk("rst_empty", 32'(bus.empty_flag), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        step(1'b1, 32'hFEFE_FEFE, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("final_empty", 32'(bus.empty_flag), 32'd1);

        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
